// File: rtl/panda_pkg.sv
// Shared types and constants for the Panda core front end.
package panda_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE        = 2'd0,
        FETCH_WAIT_GNT    = 2'd1,
        FETCH_WAIT_RVALID = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/panda_if_stage.sv
// Panda instruction fetch stage: PC, single-outstanding fetch FSM and a
// one-entry output register towards decode, with redirect flush.
module panda_if_stage
    import panda_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        pc_set_i,
    input  logic [31:0] pc_target_i,
    output logic        instr_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_inc_o
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  pc_q;
    logic [31:0]  addr_q;
    logic         kill_q;

    logic slot_free;
    logic req;
    logic accept;
    logic resp;
    logic fill;

    always_comb begin
        slot_free = !instr_valid_o || id_ready_i;
        state_d   = state_q;
        req       = 1'b0;
        unique case (state_q)
            FETCH_IDLE: begin
                req = slot_free && !pc_set_i;
                if (req) begin
                    state_d = instr_gnt_i ? FETCH_WAIT_RVALID : FETCH_WAIT_GNT;
                end
            end
            FETCH_WAIT_GNT: begin
                req = 1'b1;
                if (instr_gnt_i) begin
                    state_d = FETCH_WAIT_RVALID;
                end
            end
            FETCH_WAIT_RVALID: begin
                if (instr_rvalid_i) begin
                    state_d = FETCH_IDLE;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase

        accept = req && instr_gnt_i;
        resp   = (state_q == FETCH_WAIT_RVALID) && instr_rvalid_i;
        fill   = resp && !kill_q && !pc_set_i;
    end

    assign instr_req_o = req && rst_ni;
    // A held request keeps its captured address even after pc_q takes a redirect target.
    assign instr_addr_o = (state_q == FETCH_WAIT_GNT) ? addr_q : pc_q;
    assign pc_inc_o     = pc_o + 32'd4;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= FETCH_IDLE;
            pc_q          <= BOOT_ADDR;
            addr_q        <= BOOT_ADDR;
            kill_q        <= 1'b0;
            instr_valid_o <= 1'b0;
            instr_o       <= INSTR_NOP;
            pc_o          <= BOOT_ADDR;
        end else begin
            state_q <= state_d;

            if (state_q == FETCH_IDLE && req) begin
                addr_q <= pc_q;
            end

            if (pc_set_i) begin
                pc_q <= pc_target_i & WORD_MASK;
            end else if (accept && !kill_q) begin
                pc_q <= pc_q + 32'd4;
            end

            if (resp) begin
                kill_q <= 1'b0;
            end else if (pc_set_i && state_q != FETCH_IDLE) begin
                kill_q <= 1'b1;
            end

            if (pc_set_i) begin
                instr_valid_o <= 1'b0;
            end else if (fill) begin
                instr_valid_o <= 1'b1;
                instr_o       <= instr_rdata_i;
                pc_o          <= addr_q;
            end else if (instr_valid_o && id_ready_i) begin
                instr_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_panda_if_stage.sv
// Scoreboard bench for panda_if_stage: randomized memory/decode/redirect
// stimulus checked against an expected program-order instruction stream.
module tb_panda_if_stage;
    import panda_pkg::*;

    localparam logic [31:0] BOOT = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        pc_set_i = 1'b0;
    logic [31:0] pc_target_i = '0;
    logic        instr_valid_o;
    logic        id_ready_i = 1'b1;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_inc_o;

    always #5 clk = ~clk;

    panda_if_stage #(.BOOT_ADDR(BOOT)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .instr_req_o   (instr_req_o),
        .instr_addr_o  (instr_addr_o),
        .instr_gnt_i   (instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i (instr_rdata_i),
        .pc_set_i      (pc_set_i),
        .pc_target_i   (pc_target_i),
        .instr_valid_o (instr_valid_o),
        .id_ready_i    (id_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_inc_o      (pc_inc_o)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned n_deliv = 0;

    // Expected program-order PCs still to be delivered to decode.
    logic [31:0] exp_q[$];
    logic        first_pending = 1'b0;
    logic [31:0] first_addr = '0;

    // Memory responder knobs and state.
    int unsigned gnt_mode = 0;   // 0 always, 1 random, 2 never
    int unsigned lat_min = 0;
    int unsigned lat_max = 0;
    logic        spur_en = 1'b0;
    logic        spur_force = 1'b0;
    logic        outstanding = 1'b0;
    logic [31:0] out_addr = '0;
    int unsigned wait_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013 ^ (a * 32'd2654435761);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: bounded wait expired", name);
    endtask

    task automatic expect_stream(input logic [31:0] base);
        logic [31:0] a;
        a = {base[31:2], 2'b00};
        exp_q.delete();
        first_pending = 1'b1;
        first_addr    = a;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(a);
            a = a + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] t);
        pc_set_i    = 1'b1;
        pc_target_i = t;
        expect_stream(t);
        tick();
        pc_set_i = 1'b0;
    endtask

    task automatic wait_hs();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            found = instr_req_o && instr_gnt_i;
        end
        if (!found) fail_now("wait_hs");
        tick();
    endtask

    task automatic wait_req(input int unsigned mode_after);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            found = instr_req_o && !instr_gnt_i;
        end
        if (!found) fail_now("wait_req");
        gnt_mode = mode_after;
        tick();
    endtask

    task automatic wait_valid();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            found = instr_valid_o;
        end
        if (!found) fail_now("wait_valid");
        tick();
    endtask

    // Memory model: one outstanding read, reset together with the core.
    initial begin : responder
        logic        s_rst;
        logic        s_hs;
        logic        s_rv;
        logic [31:0] s_addr;
        forever begin
            @(negedge clk);
            s_rst  = rst_n;
            s_hs   = instr_req_o && instr_gnt_i;
            s_addr = instr_addr_o;
            s_rv   = instr_rvalid_i && outstanding;
            @(posedge clk);
            #1;
            if (!s_rst) begin
                outstanding = 1'b0;
                wait_cnt    = 0;
            end else begin
                if (s_rv) outstanding = 1'b0;
                if (s_hs) begin
                    outstanding = 1'b1;
                    out_addr    = s_addr;
                    wait_cnt    = $urandom_range(lat_min, lat_max);
                end else if (outstanding && wait_cnt > 0) begin
                    wait_cnt--;
                end
            end
            case (gnt_mode)
                0:       instr_gnt_i = 1'b1;
                1:       instr_gnt_i = ($urandom_range(0, 2) != 0);
                default: instr_gnt_i = 1'b0;
            endcase
            if (outstanding && wait_cnt == 0) begin
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = mem_word(out_addr);
            end else if (!outstanding && (spur_force || (spur_en && $urandom_range(0, 5) == 0))) begin
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = 32'hBAD0_0000 ^ 32'($urandom_range(0, 65535));
            end else begin
                instr_rvalid_i = 1'b0;
                instr_rdata_i  = $urandom;
            end
        end
    end

    // Monitor: protocol rules every cycle, scoreboard pop on each consumed instruction.
    initial begin : monitor
        logic        p_rst = 1'b1;
        logic        p_req = 1'b0;
        logic        p_gnt = 1'b0;
        logic        p_valid = 1'b0;
        logic        p_ready = 1'b0;
        logic        p_set = 1'b0;
        logic [31:0] p_addr = '0;
        logic [31:0] p_pc = '0;
        logic [31:0] p_instr = '0;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("req_in_reset", 32'(instr_req_o), 32'd0);
                if (!p_rst) begin
                    check("rst_valid", 32'(instr_valid_o), 32'd0);
                    check("rst_instr", instr_o, INSTR_NOP);
                    check("rst_pc", pc_o, BOOT);
                    check("rst_pc_inc", pc_inc_o, BOOT + 32'd4);
                end
            end else begin
                check("pc_inc", pc_inc_o, pc_o + 32'd4);
                if (instr_req_o) check("addr_align", 32'(instr_addr_o[1:0]), 32'd0);
                if (p_rst && p_req && !p_gnt) begin
                    check("req_held", 32'(instr_req_o), 32'd1);
                    check("addr_held", instr_addr_o, p_addr);
                end else if (instr_req_o) begin
                    check("req_slot_free", 32'((instr_valid_o && !id_ready_i) || pc_set_i), 32'd0);
                    check("single_outstanding", 32'(outstanding), 32'd0);
                    if (first_pending) begin
                        check("first_addr", instr_addr_o, first_addr);
                        first_pending = 1'b0;
                    end
                end
                if (p_rst && p_valid && !p_ready && !p_set) begin
                    check("stall_valid", 32'(instr_valid_o), 32'd1);
                    check("stall_pc", pc_o, p_pc);
                    check("stall_instr", instr_o, p_instr);
                end
                if (instr_valid_o && id_ready_i && !pc_set_i) begin
                    n_deliv++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_deliv_pc", pc_o, 32'hFFFF_FFFF ^ pc_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("deliv_pc", pc_o, e);
                        check("deliv_instr", instr_o, mem_word(e));
                    end
                end
            end
            p_rst   = rst_n;
            p_req   = instr_req_o;
            p_gnt   = instr_gnt_i;
            p_addr  = instr_addr_o;
            p_valid = instr_valid_o;
            p_ready = id_ready_i;
            p_set   = pc_set_i;
            p_pc    = pc_o;
            p_instr = instr_o;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] t;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_stream(BOOT);

        // Boot with zero-wait memory: fetch every other cycle.
        @(negedge clk);
        check("boot_req", 32'(instr_req_o), 32'd1);
        check("boot_addr", instr_addr_o, 32'h100);
        tick(); @(negedge clk);
        check("boot_wait_req", 32'(instr_req_o), 32'd0);
        tick(); @(negedge clk);
        check("boot_valid", 32'(instr_valid_o), 32'd1);
        check("boot_pc", pc_o, 32'h100);
        check("boot_pc_inc", pc_inc_o, 32'h104);
        check("boot_addr2", instr_addr_o, 32'h104);
        check("boot_req2", 32'(instr_req_o), 32'd1);
        tick(); tick(); @(negedge clk);
        check("boot_addr3", instr_addr_o, 32'h108);
        check("boot_pc2", pc_o, 32'h104);

        // Redirect from idle: request at N+1, valid at N+3.
        tick(); tick();
        pc_set_i    = 1'b1;
        pc_target_i = 32'h200;
        expect_stream(32'h200);
        @(negedge clk);
        check("redir_n_req", 32'(instr_req_o), 32'd0);
        tick();
        pc_set_i = 1'b0;
        @(negedge clk);
        check("redir_n1_addr", instr_addr_o, 32'h200);
        check("redir_n1_valid", 32'(instr_valid_o), 32'd0);
        tick(); @(negedge clk);
        check("redir_n2_valid", 32'(instr_valid_o), 32'd0);
        tick(); @(negedge clk);
        check("redir_n3_valid", 32'(instr_valid_o), 32'd1);
        check("redir_n3_pc", pc_o, 32'h200);
        tick();

        // Redirect while waiting for read data.
        lat_min = 2; lat_max = 2;
        wait_hs();
        redirect(32'h200);
        repeat (12) tick();

        // Grant stall.
        lat_min = 0; lat_max = 0;
        gnt_mode = 2;
        tick();
        wait_req(2);
        repeat (3) tick();
        gnt_mode = 0;
        repeat (10) tick();

        // Decode stall.
        id_ready_i = 1'b0;
        wait_valid();
        repeat (4) tick();
        id_ready_i = 1'b1;
        repeat (8) tick();

        // Redirect with grant of the held request in the same cycle.
        gnt_mode = 2;
        tick();
        wait_req(0);
        redirect(32'h403);
        repeat (14) tick();

        // Address wrap.
        redirect(32'hFFFF_FFF8);
        repeat (16) tick();

        // Reset with a fetch outstanding, then a stale rvalid.
        lat_min = 3; lat_max = 3;
        wait_hs();
        rst_n = 1'b0;
        exp_q.delete();
        first_pending = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        expect_stream(BOOT);
        lat_min = 0; lat_max = 2;
        spur_force = 1'b1;
        tick();
        spur_force = 1'b0;
        repeat (12) tick();

        // Random traffic.
        gnt_mode = 1;
        spur_en  = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            id_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                pc_set_i = 1'b0;
                rst_n    = 1'b0;
                exp_q.delete();
                first_pending = 1'b0;
                tick(); tick();
                rst_n = 1'b1;
                expect_stream(BOOT);
            end else if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 2))
                    0:       t = $urandom;
                    1:       t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                    default: t = BOOT + 32'($urandom_range(0, 255));
                endcase
                pc_set_i    = 1'b1;
                pc_target_i = t;
                expect_stream(t);
            end else begin
                pc_set_i = 1'b0;
            end
            tick();
        end
        pc_set_i   = 1'b0;
        id_ready_i = 1'b1;
        repeat (30) tick();

        check("deliveries_seen", 32'(n_deliv > 300), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
